// File: rtl/dht_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module      : dht_sensor_reader
// Description : Single-wire DHT11/DHT22 reader: start pulse, 40-bit decode,
//               checksum/timeout flags, tenths conversion, read holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_sensor_reader #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int SENSOR_TYPE   = 0,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200,
    parameter int HOLDOFF_MS    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    inout  wire         dht_data,
    output logic        busy,
    output logic        done,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [15:0] hum_raw,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_x10,
    output logic [15:0] temp_x10
);

    localparam int          c_DIV_RAW  = CLK_HZ / 1_000_000;
    localparam int          c_DIV      = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam logic [31:0] c_DIV_LAST = 32'(c_DIV - 1);
    localparam logic [15:0] c_START_US = 16'(START_LOW_US);
    localparam logic [15:0] c_THRESH   = 16'(BIT_THRESH_US);
    localparam logic [15:0] c_TO_US    = 16'(TIMEOUT_US);
    localparam logic [31:0] c_HOLD_US  = 32'(HOLDOFF_MS * 1000);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START_LOW = 4'd1,
        S_WAIT_ACK  = 4'd2,
        S_ACK_LOW   = 4'd3,
        S_ACK_HIGH  = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_CHECK     = 4'd7,
        S_DONE      = 4'd8,
        S_HOLDOFF   = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_timeout;

    logic [1:0]  r_sync;
    logic        r_prev;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] r_pre;
    logic        w_tick;
    logic [15:0] r_us;
    logic        w_us_to;
    logic [31:0] r_hold;
    logic [5:0]  r_bit_idx;
    logic [39:0] r_shift;
    logic        r_drive;
    logic        w_bit;

    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [7:0]  w_b4;
    logic [7:0]  w_sum;
    logic        w_cs_ok;
    logic [15:0] w_hum_x10;
    logic [15:0] w_temp_x10;

    // Open-drain: only ever pull low; async reset drops r_drive immediately.
    assign dht_data = r_drive ? 1'b0 : 1'bz;

    assign w_rise  = ~r_prev &  r_sync[1];
    assign w_fall  =  r_prev & ~r_sync[1];
    assign w_tick  = (r_pre == c_DIV_LAST);
    assign w_us_to = (r_us >= c_TO_US);
    assign w_bit   = (r_us > c_THRESH);

    assign w_b0    = r_shift[39:32];
    assign w_b1    = r_shift[31:24];
    assign w_b2    = r_shift[23:16];
    assign w_b3    = r_shift[15:8];
    assign w_b4    = r_shift[7:0];
    assign w_sum   = w_b0 + w_b1 + w_b2 + w_b3;
    assign w_cs_ok = (w_sum == w_b4);

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    generate
        if (SENSOR_TYPE == 1) begin : g_dht22
            assign w_hum_x10  = {w_b0, w_b1};
            assign w_temp_x10 = w_b2[7] ? (16'd0 - {1'b0, w_b2[6:0], w_b3})
                                        : {w_b2, w_b3};
        end else begin : g_dht11
            assign w_hum_x10  = ({8'd0, w_b0} * 16'd10) + {8'd0, w_b1};
            assign w_temp_x10 = ({8'd0, w_b2} * 16'd10) + {8'd0, w_b3};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_START_LOW;
            end
            S_START_LOW: begin
                if (r_us >= c_START_US) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_fall) w_next = S_ACK_LOW;
                else if (w_us_to) begin w_next = S_DONE; w_timeout = 1'b1; end
            end
            S_ACK_LOW: begin
                if (w_rise) w_next = S_ACK_HIGH;
                else if (w_us_to) begin w_next = S_DONE; w_timeout = 1'b1; end
            end
            S_ACK_HIGH: begin
                if (w_fall) w_next = S_BIT_LOW;
                else if (w_us_to) begin w_next = S_DONE; w_timeout = 1'b1; end
            end
            S_BIT_LOW: begin
                if (w_rise) w_next = S_BIT_HIGH;
                else if (w_us_to) begin w_next = S_DONE; w_timeout = 1'b1; end
            end
            S_BIT_HIGH: begin
                if (w_fall) w_next = (r_bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (w_us_to) begin w_next = S_DONE; w_timeout = 1'b1; end
            end
            S_CHECK:   w_next = S_DONE;
            S_DONE:    w_next = S_HOLDOFF;
            S_HOLDOFF: begin
                if (r_hold >= c_HOLD_US) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b11;
            r_prev       <= 1'b1;
            r_pre        <= '0;
            r_us         <= '0;
            r_hold       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_drive      <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            hum_raw      <= '0;
            temp_raw     <= '0;
            hum_x10      <= '0;
            temp_x10     <= '0;
        end else begin
            r_sync  <= {r_sync[0], dht_data};
            r_prev  <= r_sync[1];
            r_pre   <= w_tick ? 32'd0 : r_pre + 32'd1;
            r_drive <= (w_next == S_START_LOW);

            // Per-state elapsed time; restarts on every state entry.
            if (w_next != r_state)
                r_us <= '0;
            else if (w_tick && (r_us != 16'hFFFF))
                r_us <= r_us + 16'd1;

            if (r_state != S_HOLDOFF)
                r_hold <= '0;
            else if (w_tick && (r_hold != 32'hFFFF_FFFF))
                r_hold <= r_hold + 32'd1;

            if (r_state == S_ACK_HIGH) begin
                r_bit_idx <= '0;
            end else if ((r_state == S_BIT_HIGH) && w_fall) begin
                r_shift   <= {r_shift[38:0], w_bit};
                r_bit_idx <= r_bit_idx + 6'd1;
            end

            // Flags and results are loaded on the edge entering DONE so they
            // are already valid while done is high.
            if (r_state == S_CHECK) begin
                err_checksum <= ~w_cs_ok;
                err_timeout  <= 1'b0;
                if (w_cs_ok) begin
                    hum_raw  <= {w_b0, w_b1};
                    temp_raw <= {w_b2, w_b3};
                    hum_x10  <= w_hum_x10;
                    temp_x10 <= w_temp_x10;
                end
            end else if (w_timeout) begin
                err_checksum <= 1'b0;
                err_timeout  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
